// File: rtl/mixed_nested_chan_buffer.sv
// rtl/mixed_nested_chan_buffer.sv - multi-channel ready/valid FIFO buffer with arbitrated, channel-tagged output stage
module mixed_nested_chan_buffer #(
   parameter  int DSIZE    = 32,
   parameter  int NUM_CH   = 2,
   parameter  int DEPTH    = 4,
   parameter  int ARB_MODE = 0,
   localparam int CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int LW       = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic [NUM_CH-1:0]       in_vld,
   output logic [NUM_CH-1:0]       in_rdy,
   input  logic [NUM_CH*DSIZE-1:0] in_data,
   output logic                    out_vld,
   input  logic                    out_rdy,
   output logic [DSIZE-1:0]        out_data,
   output logic [CW-1:0]           out_ch,
   output logic [NUM_CH*LW-1:0]    level
);

   localparam int PW = $clog2(DEPTH);

   logic [DSIZE-1:0]  r_mem    [NUM_CH][DEPTH];
   logic [LW-1:0]     r_count  [NUM_CH];
   logic [PW-1:0]     r_wr_ptr [NUM_CH];
   logic [PW-1:0]     r_rd_ptr [NUM_CH];
   logic              r_out_vld;
   logic [DSIZE-1:0]  r_out_data;
   logic [CW-1:0]     r_out_ch;
   logic [CW-1:0]     r_rr_ptr;

   logic [NUM_CH-1:0] w_push;
   logic [NUM_CH-1:0] w_pop;
   logic [NUM_CH-1:0] w_nonempty;
   logic [NUM_CH-1:0] w_full;
   logic              w_load_en;
   logic              w_any;
   logic [CW-1:0]     w_grant;
   logic [CW-1:0]     w_rr_next;
   logic [DSIZE-1:0]  w_head;
   int                w_best;
   int                w_dist;

   // Ready comes only from the registered count, so it never depends on out_rdy
   always_comb begin
      w_nonempty = '0;
      w_full     = '0;
      in_rdy     = '0;
      w_push     = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_nonempty[c] = (r_count[c] != '0);
         w_full[c]     = (r_count[c] == LW'(DEPTH));
         in_rdy[c]     = rst_n & ~w_full[c] & ~flush;
         w_push[c]     = in_vld[c] & in_rdy[c];
      end
   end

   // Grant goes to the non-empty channel with the smallest distance from the search start
   always_comb begin
      w_any   = 1'b0;
      w_grant = '0;
      w_best  = NUM_CH;
      w_dist  = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ARB_MODE != 0)
            w_dist = c;
         else if (c >= int'(r_rr_ptr))
            w_dist = c - int'(r_rr_ptr);
         else
            w_dist = c + NUM_CH - int'(r_rr_ptr);
         if (w_nonempty[c] && (w_dist < w_best)) begin
            w_best  = w_dist;
            w_grant = CW'(c);
            w_any   = 1'b1;
         end
      end
   end

   assign w_rr_next = (w_grant == CW'(NUM_CH - 1)) ? '0 : w_grant + 1'b1;
   assign w_load_en = ~r_out_vld | out_rdy;

   always_comb begin
      w_head = '0;
      w_pop  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_grant == CW'(c))
            w_head = r_mem[c][r_rd_ptr[c]];
         w_pop[c] = w_load_en & w_any & (w_grant == CW'(c)) & ~flush;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_count[c]  <= '0;
            r_wr_ptr[c] <= '0;
            r_rd_ptr[c] <= '0;
         end
      end else if (flush) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_count[c]  <= '0;
            r_wr_ptr[c] <= '0;
            r_rd_ptr[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_push[c])
               r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
            if (w_pop[c])
               r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
            r_count[c] <= r_count[c] + LW'(w_push[c]) - LW'(w_pop[c]);
         end
      end
   end

   // Storage is never reset; the counts alone decide what is valid
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_push[c])
            r_mem[c][r_wr_ptr[c]] <= in_data[c*DSIZE +: DSIZE];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_vld  <= 1'b0;
         r_out_data <= '0;
         r_out_ch   <= '0;
         r_rr_ptr   <= '0;
      end else if (flush) begin
         r_out_vld  <= 1'b0;
         r_rr_ptr   <= '0;
      end else if (w_load_en) begin
         if (w_any) begin
            r_out_vld  <= 1'b1;
            r_out_data <= w_head;
            r_out_ch   <= w_grant;
            if (ARB_MODE == 0)
               r_rr_ptr <= w_rr_next;
         end else begin
            r_out_vld  <= 1'b0;
         end
      end
   end

   always_comb begin
      level = '0;
      for (int c = 0; c < NUM_CH; c++)
         level[c*LW +: LW] = r_count[c];
   end

   assign out_vld  = r_out_vld;
   assign out_data = r_out_data;
   assign out_ch   = r_out_ch;

endmodule
